// File: rtl/ahb_input_stage_ble.sv
// Address-phase input stage for the BLE master port: holds the address phase while the port is
// not granted or the slave is busy. Optional master-lock support is enabled by BLE_INSTAGE_LOCK_EN.
module ahb_input_stage_ble #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSELS,
    input  logic [ADDR_WIDTH-1:0] HADDRS,
    input  logic [1:0]            HTRANSS,
    input  logic                  HWRITES,
    input  logic [2:0]            HSIZES,
    input  logic [2:0]            HBURSTS,
    input  logic [3:0]            HPROTS,
    input  logic                  HMASTLOCKS,
    input  logic                  HREADYS,
    input  logic                  grant_in,
    input  logic                  HREADYM,
    input  logic                  HRESPM,
    output logic                  req_port,
    output logic                  HSELM,
    output logic [ADDR_WIDTH-1:0] HADDRM,
    output logic [1:0]            HTRANSM,
    output logic                  HWRITEM,
    output logic [2:0]            HSIZEM,
    output logic [2:0]            HBURSTM,
    output logic [3:0]            HPROTM,
    output logic                  HMASTLOCKM,
    output logic                  HREADYOUTS,
    output logic                  HRESPS
);

    logic                  pending_q, pending_d;
    logic                  data_phase_q, data_phase_d;
    logic                  lock_hold;
    logic [ADDR_WIDTH-1:0] haddr_q;
    logic [1:0]            htrans_q;
    logic                  hwrite_q;
    logic [2:0]            hsize_q;
    logic [2:0]            hburst_q;
    logic [3:0]            hprot_q;

    logic trans_valid, capture, release_held, live_fwd;

    // Only NONSEQ/SEQ phases the master has actually issued count as transfers.
    assign trans_valid  = HSELS & HTRANSS[1] & HREADYS;
    assign capture      = trans_valid & ~(grant_in & HREADYM & ~pending_q);
    assign release_held = pending_q & grant_in & HREADYM;
    assign live_fwd     = trans_valid & grant_in & HREADYM & ~pending_q;

    always_comb begin
        pending_d    = pending_q;
        data_phase_d = data_phase_q;
        if (capture)
            pending_d = 1'b1;
        else if (release_held)
            pending_d = 1'b0;
        if (release_held | live_fwd)
            data_phase_d = 1'b1;
        else if (HREADYM)
            data_phase_d = 1'b0;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pending_q    <= 1'b0;
            data_phase_q <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            data_phase_q <= data_phase_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            haddr_q  <= '0;
            htrans_q <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= '0;
            hburst_q <= '0;
            hprot_q  <= '0;
        end else if (capture) begin
            haddr_q  <= HADDRS;
            htrans_q <= HTRANSS;
            hwrite_q <= HWRITES;
            hsize_q  <= HSIZES;
            hburst_q <= HBURSTS;
            hprot_q  <= HPROTS;
        end
    end

`ifdef BLE_INSTAGE_LOCK_EN
    logic lock_hold_q, lock_hold_d;
    logic hmastlock_q;

    // Keeps the port requested across IDLE cycles inside a locked sequence.
    always_comb begin
        lock_hold_d = lock_hold_q;
        if (trans_valid & HMASTLOCKS)
            lock_hold_d = 1'b1;
        else if (HREADYM & ~HMASTLOCKS)
            lock_hold_d = 1'b0;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            lock_hold_q <= 1'b0;
            hmastlock_q <= 1'b0;
        end else begin
            lock_hold_q <= lock_hold_d;
            if (capture)
                hmastlock_q <= HMASTLOCKS;
        end
    end

    assign lock_hold  = lock_hold_q;
    assign HMASTLOCKM = pending_q ? hmastlock_q : HMASTLOCKS;
`else
    logic lock_unused;

    assign lock_unused = HMASTLOCKS;
    assign lock_hold   = 1'b0;
    assign HMASTLOCKM  = 1'b0;
`endif

    assign req_port   = pending_q | trans_valid | lock_hold;
    assign HSELM      = pending_q | HSELS;
    assign HADDRM     = pending_q ? haddr_q  : HADDRS;
    assign HTRANSM    = pending_q ? htrans_q : HTRANSS;
    assign HWRITEM    = pending_q ? hwrite_q : HWRITES;
    assign HSIZEM     = pending_q ? hsize_q  : HSIZES;
    assign HBURSTM    = pending_q ? hburst_q : HBURSTS;
    assign HPROTM     = pending_q ? hprot_q  : HPROTS;
    assign HREADYOUTS = pending_q ? 1'b0 : (data_phase_q ? HREADYM : 1'b1);
    assign HRESPS     = data_phase_q ? HRESPM : 1'b0;

endmodule

// File: tb/tb_ahb_input_stage_ble.sv
// Directed bench for ahb_input_stage_ble: expectations are queued with each cycle's stimulus and
// compared against the outputs sampled mid-cycle.
module tb_ahb_input_stage_ble;

`ifdef BLE_INSTAGE_LOCK_EN
    localparam logic LOCK_EN = 1'b1;
`else
    localparam logic LOCK_EN = 1'b0;
`endif

    localparam int S_REQ = 0, S_SELM = 1, S_ADDRM = 2, S_TRANSM = 3, S_RDY = 4,
                   S_RESP = 5, S_LOCKM = 6, S_WRITEM = 7, S_BURSTM = 8, S_SIZEM = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsels, hwrites, hmastlocks, hreadys, grant_in, hreadym, hrespm;
    logic [31:0] haddrs;
    logic [1:0]  htranss;
    logic [2:0]  hsizes, hbursts;
    logic [3:0]  hprots;
    logic        req_port, hselm, hwritem, hmastlockm, hreadyouts, hresps;
    logic [31:0] haddrm;
    logic [1:0]  htransm;
    logic [2:0]  hsizem, hburstm;
    logic [3:0]  hprotm;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ahb_input_stage_ble #(.ADDR_WIDTH(32)) dut (
        .HCLK(clk), .HRESET(rst), .HSELS(hsels), .HADDRS(haddrs), .HTRANSS(htranss),
        .HWRITES(hwrites), .HSIZES(hsizes), .HBURSTS(hbursts), .HPROTS(hprots),
        .HMASTLOCKS(hmastlocks), .HREADYS(hreadys), .grant_in(grant_in), .HREADYM(hreadym),
        .HRESPM(hrespm), .req_port(req_port), .HSELM(hselm), .HADDRM(haddrm),
        .HTRANSM(htransm), .HWRITEM(hwritem), .HSIZEM(hsizem), .HBURSTM(hburstm),
        .HPROTM(hprotm), .HMASTLOCKM(hmastlockm), .HREADYOUTS(hreadyouts), .HRESPS(hresps)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            S_REQ:    return {31'd0, req_port};
            S_SELM:   return {31'd0, hselm};
            S_ADDRM:  return haddrm;
            S_TRANSM: return {30'd0, htransm};
            S_RDY:    return {31'd0, hreadyouts};
            S_RESP:   return {31'd0, hresps};
            S_LOCKM:  return {31'd0, hmastlockm};
            S_WRITEM: return {31'd0, hwritem};
            S_BURSTM: return {29'd0, hburstm};
            default:  return {29'd0, hsizem};
        endcase
    endfunction

    task automatic expect_out(input string tag, input int sig, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    // Inputs are driven just after the falling edge; outputs are sampled 2 ns later.
    task automatic step(input string name);
        int   n;
        exp_t e;
        #2;
        n = sb_q.size();
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, observe(e.sig), e.exp);
        end
        $display("txn %s: %0d checks", name, n);
        @(negedge clk);
    endtask

    task automatic drv(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                       input logic wr, input logic [2:0] burst, input logic lock,
                       input logic readys, input logic grant, input logic readym,
                       input logic respm);
        hsels      = sel;
        htranss    = trans;
        haddrs     = addr;
        hwrites    = wr;
        hbursts    = burst;
        hmastlocks = lock;
        hreadys    = readys;
        grant_in   = grant;
        hreadym    = readym;
        hrespm     = respm;
        hsizes     = 3'b010;
        hprots     = 4'b0011;
    endtask

    initial begin
        logic rsel;
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        @(negedge clk);

        // Reset with random stimulus
        for (int i = 0; i < 2; i++) begin
            rsel = 1'($urandom);
            drv(rsel, 2'($urandom), $urandom, 1'($urandom), 3'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if (i == 1) begin
                expect_out("rst_rdy", S_RDY, 1);
                expect_out("rst_resp", S_RESP, 0);
                expect_out("rst_selm", S_SELM, {31'd0, rsel});
            end
            step("reset");
        end
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        expect_out("post_rst_req", S_REQ, 0);
        expect_out("post_rst_rdy", S_RDY, 1);
        expect_out("post_rst_resp", S_RESP, 0);
        expect_out("post_rst_selm", S_SELM, 0);
        step("post_reset");

        // BUSY is never captured, even when not granted
        drv(1, 2'b01, 32'h500, 0, 0, 0, 1, 0, 1, 0);
        expect_out("busy_req", S_REQ, 0);
        expect_out("busy_rdy", S_RDY, 1);
        step("busy");
        drv(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        expect_out("busy_after_rdy", S_RDY, 1);
        expect_out("busy_after_selm", S_SELM, 0);
        step("busy_after");

        // Granted single write: zero-cycle forward
        drv(1, 2'b10, 32'h1000, 1, 0, 0, 1, 1, 1, 0);
        expect_out("gw_addr", S_ADDRM, 32'h1000);
        expect_out("gw_trans", S_TRANSM, 2);
        expect_out("gw_write", S_WRITEM, 1);
        expect_out("gw_selm", S_SELM, 1);
        expect_out("gw_req", S_REQ, 1);
        expect_out("gw_rdy", S_RDY, 1);
        step("granted_write");
        drv(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        expect_out("gw_dp_rdy", S_RDY, 1);
        expect_out("gw_dp_req", S_REQ, 0);
        expect_out("gw_dp_resp", S_RESP, 0);
        step("granted_write_data");

        // Hold: not granted, released three cycles later
        drv(1, 2'b10, 32'h2004, 0, 0, 0, 1, 0, 1, 0);
        expect_out("hold_cap_addr", S_ADDRM, 32'h2004);
        expect_out("hold_cap_rdy", S_RDY, 1);
        expect_out("hold_cap_req", S_REQ, 1);
        step("hold_capture");
        for (int i = 0; i < 2; i++) begin
            drv(0, 0, 32'hDEAD_0000, 1, 0, 0, 0, 0, 1, 0);
            expect_out("hold_rdy", S_RDY, 0);
            expect_out("hold_addr", S_ADDRM, 32'h2004);
            expect_out("hold_trans", S_TRANSM, 2);
            expect_out("hold_write", S_WRITEM, 0);
            expect_out("hold_size", S_SIZEM, 2);
            expect_out("hold_selm", S_SELM, 1);
            expect_out("hold_req", S_REQ, 1);
            step("hold_wait");
        end
        drv(0, 0, 32'hDEAD_0000, 1, 0, 0, 0, 1, 1, 0);
        expect_out("rel_addr", S_ADDRM, 32'h2004);
        expect_out("rel_trans", S_TRANSM, 2);
        expect_out("rel_rdy", S_RDY, 0);
        expect_out("rel_req", S_REQ, 1);
        step("hold_release");
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        expect_out("rel_dp_rdy0", S_RDY, 0);
        expect_out("rel_dp_req", S_REQ, 0);
        expect_out("rel_dp_addr", S_ADDRM, 0);
        step("hold_data_wait");
        drv(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        expect_out("rel_dp_rdy1", S_RDY, 1);
        step("hold_data_done");

        // INCR4 with two slave wait states on beat 2's data phase
        drv(1, 2'b10, 32'h100, 0, 3'b011, 0, 1, 1, 1, 0);
        expect_out("b1_addr", S_ADDRM, 32'h100);
        expect_out("b1_trans", S_TRANSM, 2);
        expect_out("b1_burst", S_BURSTM, 3);
        expect_out("b1_rdy", S_RDY, 1);
        step("incr4_b1");
        drv(1, 2'b11, 32'h104, 0, 3'b011, 0, 1, 1, 1, 0);
        expect_out("b2_addr", S_ADDRM, 32'h104);
        expect_out("b2_trans", S_TRANSM, 3);
        expect_out("b2_rdy", S_RDY, 1);
        step("incr4_b2");
        for (int i = 0; i < 2; i++) begin
            drv(1, 2'b11, 32'h108, 0, 3'b011, 0, 0, 1, 0, 0);
            expect_out("ws_rdy", S_RDY, 0);
            expect_out("ws_addr", S_ADDRM, 32'h108);
            step("incr4_wait");
        end
        drv(1, 2'b11, 32'h108, 0, 3'b011, 0, 1, 1, 1, 0);
        expect_out("b3_addr", S_ADDRM, 32'h108);
        expect_out("b3_rdy", S_RDY, 1);
        step("incr4_b3");
        drv(1, 2'b11, 32'h10C, 0, 3'b011, 0, 1, 1, 1, 0);
        expect_out("b4_addr", S_ADDRM, 32'h10C);
        expect_out("b4_rdy", S_RDY, 1);
        step("incr4_b4");
        drv(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        expect_out("b4_dp_rdy", S_RDY, 1);
        expect_out("b4_dp_req", S_REQ, 0);
        step("incr4_end");

        // Two-cycle ERROR response
        drv(1, 2'b10, 32'h300, 1, 0, 0, 1, 1, 1, 0);
        expect_out("err_addr_rdy", S_RDY, 1);
        expect_out("err_addr_resp", S_RESP, 0);
        step("err_addr");
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        expect_out("err1_resp", S_RESP, 1);
        expect_out("err1_rdy", S_RDY, 0);
        step("err_cycle1");
        drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        expect_out("err2_resp", S_RESP, 1);
        expect_out("err2_rdy", S_RDY, 1);
        step("err_cycle2");
        drv(0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
        expect_out("err_masked_resp", S_RESP, 0);
        step("err_after");

        // Locked NONSEQ, IDLE, NONSEQ
        drv(1, 2'b10, 32'h400, 0, 0, 1, 1, 1, 1, 0);
        expect_out("lk1_req", S_REQ, 1);
        expect_out("lk1_lockm", S_LOCKM, {31'd0, LOCK_EN});
        step("lock_nonseq1");
        drv(1, 2'b00, 32'h404, 0, 0, 1, 1, 1, 1, 0);
        expect_out("lk_idle_req", S_REQ, {31'd0, LOCK_EN});
        expect_out("lk_idle_lockm", S_LOCKM, {31'd0, LOCK_EN});
        step("lock_idle");
        drv(1, 2'b10, 32'h404, 0, 0, 1, 1, 1, 1, 0);
        expect_out("lk2_req", S_REQ, 1);
        step("lock_nonseq2");
        drv(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        expect_out("lk_unlock_req", S_REQ, {31'd0, LOCK_EN});
        step("lock_unlock");
        drv(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        expect_out("lk_done_req", S_REQ, 0);
        step("lock_done");

        // Reset while a transfer is held
        drv(1, 2'b10, 32'h600, 0, 0, 0, 1, 0, 1, 0);
        expect_out("rh_cap_rdy", S_RDY, 1);
        expect_out("rh_cap_req", S_REQ, 1);
        step("rsthold_capture");
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        expect_out("rh_held_rdy", S_RDY, 0);
        expect_out("rh_held_addr", S_ADDRM, 32'h600);
        step("rsthold_reset");
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        expect_out("rh_after_rdy", S_RDY, 1);
        expect_out("rh_after_req", S_REQ, 0);
        expect_out("rh_after_selm", S_SELM, 0);
        expect_out("rh_after_addr", S_ADDRM, 0);
        step("rsthold_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
